// File: rtl/burst_memory.sv
// Byte-addressable big-endian memory with a registered 1/4/8/16-word burst engine.
// Optional address fault checking is enabled by defining BURST_MEM_ADDR_CHECK_EN.
module burst_memory #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int OFF_W      = $clog2(DEPTH_BYTES);
    localparam int EXT_W      = ADDR_WIDTH + 2;

    // Handshake: a request is taken on any rising edge where enable=1 and busy=0;
    // busy stays high for the N-1 remaining beats and all request inputs except
    // data_in are ignored until it falls. Reads return one word per data_valid cycle.

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       beat_q, beat_d;
    logic [3:0]       last_q, last_d;
    logic             rw_q, rw_d;
    logic [EXT_W-1:0] base_q, base_d;

    logic             do_beat;
    logic             cur_rw;
    logic [EXT_W-1:0] cur_base;
    logic [3:0]       cur_beat;

    logic [EXT_W-1:0] req_diff;
    logic [EXT_W-1:0] req_base;
    logic [EXT_W-1:0] beat_off;
    logic [OFF_W-1:0] mem_idx;
    logic             beat_fault;
    logic             wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [7:0] mem [DEPTH_BYTES];

    function automatic logic [3:0] last_beat(input logic [1:0] size);
        case (size)
            2'b00:   return 4'd0;
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            default: return 4'd15;
        endcase
    endfunction

    // Offset is kept sign-extended two bits wider so underflow below START_ADDR
    // and overflow past the end stay distinguishable from in-range offsets.
    assign req_diff = {2'b00, address} - {2'b00, START_ADDR};
    assign req_base = req_diff & ~EXT_W'(BYTES - 1);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d   = last_q;
        rw_d     = rw_q;
        base_d   = base_q;
        do_beat  = 1'b0;
        cur_rw   = rw_q;
        cur_base = base_q;
        cur_beat = beat_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    do_beat  = 1'b1;
                    cur_rw   = rw;
                    cur_base = req_base;
                    cur_beat = 4'd0;
                    rw_d     = rw;
                    base_d   = req_base;
                    last_d   = last_beat(access_size);
                    if (access_size != 2'b00) begin
                        state_d = BURST;
                        beat_d  = 4'd1;
                    end
                end
            end
            BURST: begin
                do_beat = 1'b1;
                if (beat_q == last_q) begin
                    state_d = IDLE;
                    beat_d  = 4'd0;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
        endcase
    end

    assign beat_off = cur_base + (EXT_W'(cur_beat) << BYTE_SHIFT);
    assign mem_idx  = beat_off[OFF_W-1:0];

`ifdef BURST_MEM_ADDR_CHECK_EN
    assign beat_fault = beat_off[EXT_W-1] ||
                        (beat_off >= EXT_W'(DEPTH_BYTES));
`else
    logic unused_off_hi;
    assign unused_off_hi = ^beat_off[EXT_W-1:OFF_W];
    assign beat_fault    = 1'b0;
`endif

    assign wr_en = do_beat && !cur_rw && !beat_fault && !reset;

    // Big-endian: lowest byte offset carries the most significant byte.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            rd_word[DATA_WIDTH-1-8*i -: 8] = mem[mem_idx + OFF_W'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[mem_idx + OFF_W'(i)] <= data_in[DATA_WIDTH-1-8*i -: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= 4'd0;
            last_q     <= 4'd0;
            rw_q       <= 1'b0;
            base_q     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            rw_q       <= rw_d;
            base_q     <= base_d;
            data_valid <= do_beat && cur_rw;
            if (do_beat && cur_rw) begin
                data_out <= beat_fault ? '0 : rd_word;
            end
        end
    end

`ifdef BURST_MEM_ADDR_CHECK_EN
    logic err_q;

    // A newly accepted request restarts the flag from its own first beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && enable) begin
            err_q <= beat_fault;
        end else if (do_beat && beat_fault) begin
            err_q <= 1'b1;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    assign busy = (state_q == BURST);

endmodule
